alu_flags_reg: RTL
==================

Name: alu_flags_reg

Overview:
- Parametrised, registered successor to the combinational ALU flag selector.
- Computes Carry, Negative, Zero (equal) and Overflow from ALU operands, result and carry-out for a WIDTH-bit ALU.
- Per-opcode update mask: flags that an op does not affect are held, not zeroed.
- Also provides a sticky overflow bit and a saturating overflow event counter; sits between the ALU datapath and the control/status logic.

Parameters:
- WIDTH, 4, ALU operand/result width in bits (>= 2).
- COUNT_W, 8, width of the overflow event counter (>= 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  ALU result valid this cycle
- op  in  4  ALU selector (alu_pkg opcode)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- result  in  WIDTH  ALU result
- carry_in  in  1  ALU carry-out (add/sub), or last bit shifted out (shifts)
- flag_clr  in  1  clear C/N/Z/V registers
- sticky_clr  in  1  clear sticky_ovf and ovf_count
- carry_flag  out  1  registered C
- neg_flag  out  1  registered N
- zero_flag  out  1  registered Z (equal)
- ovf_flag  out  1  registered V
- flags_valid  out  1  one-cycle pulse: flags updated from a valid_in
- sticky_ovf  out  1  set by any recorded overflow, held until sticky_clr
- ovf_count  out  COUNT_W  saturating count of recorded overflows

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). While rst=1 at a clk edge, every output goes to 0 and all inputs are ignored.
- Latency: flags reflect the inputs sampled at edge N and are visible after edge N. flags_valid=1 for exactly the cycle following each valid_in=1, including unknown ops.
- Raw flag calculation, with M = WIDTH-1:
  - Z = (result == 0)
  - N = result[M]
  - C = carry_in
  - V on ADD = (a[M]==b[M]) & (result[M]!=a[M])
  - V on SUB/CMP = (a[M]!=b[M]) & (result[M]!=a[M])
- Update mask per op:
  - 0 ADD, 1 SUB, 7 CMP: C, N, Z, V
  - 2 AND, 3 OR, 4 XOR: N, Z (C, V held)
  - 5 SHL, 6 SHR: C, N, Z (V held)
  - 8..15 reserved: nothing updated (all held)
- CMP updates flags only; it has no other side effect.
- Precedence on the C/N/Z/V registers: rst > flag_clr > masked update > hold. If flag_clr and valid_in occur together, the clear wins, but flags_valid still pulses.
- Recorded overflow = valid_in & V-masked-in & raw V.
- sticky_ovf:
  - Set by a recorded overflow.
  - Cleared by sticky_clr.
  - If both occur in the same cycle, set dominates (sticky_ovf=1).
- ovf_count:
  - Increments by 1 on each recorded overflow and saturates at all-ones, with no wrap.
  - sticky_clr with a simultaneous recorded overflow loads 1; sticky_clr alone loads 0.
  - flag_clr does not affect sticky_ovf or ovf_count.
- valid_in=0: all registers hold, except that flag_clr and sticky_clr still act.
- Reset mid-stream: an op sampled in the same cycle as rst is discarded, and no flags_valid follows.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode enum (OP_ADD..OP_CMP)
  - flag index constants (FLAG_C, FLAG_N, FLAG_Z, FLAG_V)
  - an update-mask function op -> 4-bit mask
- One combinational sub-module, alu_flag_calc: computes raw C/N/Z/V and the mask from op, a, b, result and carry_in.
- The top level holds the flag registers, flags_valid, the sticky bit and the counter.

Test Plan:
All cases use WIDTH=4, COUNT_W=8 unless stated.
- ADD a=7, b=1, result=8, carry_in=0, valid_in=1 -> next cycle: C=0, N=1, Z=0, V=1, flags_valid=1, sticky_ovf=1, ovf_count=1.
- SUB a=5, b=5, result=0, carry_in=1 -> C=1, N=0, Z=1, V=0. Then AND with result=4'hF, carry_in=0 -> N=1, Z=0, C still 1, V still 0.
- Reserved op 4'hA after any ADD -> all four flags unchanged, flags_valid=1 for one cycle.
- COUNT_W=2: five successive overflowing ADDs -> ovf_count steps 1,2,3,3,3.
  - sticky_clr on the same cycle as a sixth overflow -> ovf_count=1, sticky_ovf=1.
  - sticky_clr alone -> ovf_count=0, sticky_ovf=0.
- flag_clr together with an overflowing ADD (7+1) -> C/N/Z/V=0, flags_valid=1, sticky_ovf=1, ovf_count increments.
- rst asserted for one cycle during a valid ADD stream -> all outputs 0 the next cycle, no flags_valid for the dropped op; the next valid op updates normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag bit positions and the
// per-opcode flag update mask.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_CMP = 4'd7
  } opcode_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 3;

  // Bit set = the op writes that flag; clear = the flag is held.
  function automatic logic [3:0] updateMask(input logic [3:0] op);
    logic [3:0] mask;
    mask = '0;
    case (op)
      OP_ADD, OP_SUB, OP_CMP: mask = '1;
      OP_AND, OP_OR, OP_XOR: begin
        mask[FLAG_N] = 1'b1;
        mask[FLAG_Z] = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        mask[FLAG_C] = 1'b1;
        mask[FLAG_N] = 1'b1;
        mask[FLAG_Z] = 1'b1;
      end
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational raw C/N/Z/V computation and update mask for one ALU op.
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic             carryIn,
  output logic [3:0]       rawFlags,
  output logic [3:0]       updMask
);

  localparam int unsigned M = WIDTH - 1;

  logic isSub;
  // Overflow only depends on sign bits; the low operand bits are intentionally unused.
  logic unusedOperandBits;

  assign unusedOperandBits = ^{a[M-1:0], b[M-1:0]};
  assign isSub = (op == OP_SUB) || (op == OP_CMP);

  always_comb begin
    rawFlags         = '0;
    rawFlags[FLAG_C] = carryIn;
    rawFlags[FLAG_N] = result[M];
    rawFlags[FLAG_Z] = (result == '0);
    if (isSub)
      rawFlags[FLAG_V] = (a[M] != b[M]) && (result[M] != a[M]);
    else
      rawFlags[FLAG_V] = (a[M] == b[M]) && (result[M] != a[M]);
    updMask = updateMask(op);
  end

endmodule

// File: rtl/alu_flags_reg.sv
// Registered ALU status flags with per-op hold mask, sticky overflow bit
// and saturating overflow event counter.
module alu_flags_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   result,
  input  logic               carry_in,
  input  logic               flag_clr,
  input  logic               sticky_clr,
  output logic               carry_flag,
  output logic               neg_flag,
  output logic               zero_flag,
  output logic               ovf_flag,
  output logic               flags_valid,
  output logic               sticky_ovf,
  output logic [COUNT_W-1:0] ovf_count
);

  logic [3:0]         rawFlags;
  logic [3:0]         updMask;
  logic [3:0]         flagsQ;
  logic               validQ;
  logic               stickyQ;
  logic [COUNT_W-1:0] countQ;
  logic               recOvf;

  alu_flag_calc #(.WIDTH(WIDTH)) calc (
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .carryIn (carry_in),
    .rawFlags(rawFlags),
    .updMask (updMask)
  );

  assign recOvf = valid_in && updMask[FLAG_V] && rawFlags[FLAG_V];

  always_ff @(posedge clk) begin
    if (rst) begin
      flagsQ  <= '0;
      validQ  <= 1'b0;
      stickyQ <= 1'b0;
      countQ  <= '0;
    end else begin
      validQ <= valid_in;

      if (flag_clr)
        flagsQ <= '0;
      else if (valid_in)
        flagsQ <= (flagsQ & ~updMask) | (rawFlags & updMask);

      // A new overflow outranks a same-cycle clear, so nothing is lost.
      if (recOvf)
        stickyQ <= 1'b1;
      else if (sticky_clr)
        stickyQ <= 1'b0;

      if (sticky_clr)
        countQ <= recOvf ? COUNT_W'(1) : '0;
      else if (recOvf && (countQ != '1))
        countQ <= countQ + COUNT_W'(1);
    end
  end

  assign carry_flag  = flagsQ[FLAG_C];
  assign neg_flag    = flagsQ[FLAG_N];
  assign zero_flag   = flagsQ[FLAG_Z];
  assign ovf_flag    = flagsQ[FLAG_V];
  assign flags_valid = validQ;
  assign sticky_ovf  = stickyQ;
  assign ovf_count   = countQ;

endmodule
